uart_tx: RTL
============

Name: uart_tx

Overview:
- UART serializer for the transmit direction of the UART link.
- Accepts a parallel byte with a valid strobe and emits a frame on TX_OUT:
  - start bit (0)
  - DATA_WIDTH data bits, LSB first
  - optional parity bit
  - stop bit (1)
- Each bit lasts Prescale clock cycles, matching the receiver's oversampling setting.
- Parity polarity is identical to the receive-side parity checker: PAR_TYP=1 is odd, 0 is even.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_W, 6, width of Prescale input and of the per-bit cycle counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- P_DATA  input  DATA_WIDTH  parallel payload; sampled only on acceptance.
- Data_Valid  input  1  request to send P_DATA; accepted only when busy=0.
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
- PAR_TYP  input  1  1 = odd, 0 = even; sampled on acceptance.
- Prescale  input  PRESCALE_W  clock cycles per bit; 0 treated as 1; sampled on acceptance.
- TX_OUT  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, TX_OUT=1, busy=0, counters=0, latched data/config=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Acceptance:
  - Occurs in IDLE when Data_Valid=1 at a rising edge.
  - Latches P_DATA, PAR_EN, PAR_TYP and Prescale.
  - Moves to START.
- Output timing:
  - TX_OUT and busy are registered.
  - TX_OUT=0 and busy=1 from the first edge after acceptance (latency 1 cycle).
- Bit timing:
  - A cycle counter runs 0..Prescale-1 inside each bit; the bit advances when the counter reaches Prescale-1.
  - Each bit is exactly Prescale cycles wide.
- Transitions:
  - START -> DATA.
  - DATA: bit index 0..DATA_WIDTH-1, TX_OUT = data[index].
  - After the last data bit: -> PARITY if PAR_EN, else -> STOP.
  - PARITY: TX_OUT = ^data when even; ~(^data) when odd.
  - STOP: TX_OUT=1 for Prescale cycles, then -> IDLE with busy=0 on the same edge.
- Frame length: (2 + DATA_WIDTH + PAR_EN) * Prescale cycles of busy=1.
- Back-to-back: Data_Valid sampled in the first IDLE cycle after STOP is accepted, giving a minimum gap of 1 idle cycle (TX_OUT=1).
- Data_Valid while busy=1: ignored; not queued.
- Inputs changing mid-frame (P_DATA, PAR_EN, PAR_TYP, Prescale): no effect on the current frame.
- Reset mid-frame: TX_OUT returns to 1 immediately (asynchronous); the partial frame is abandoned.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined:
  - STOP lasts 2*Prescale cycles.
  - Frame length becomes (3 + DATA_WIDTH + PAR_EN) * Prescale.
- Undefined: single stop bit as above.
- Either way, busy falls at the end of the final stop bit.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - PAR_EVEN=0 and PAR_ODD=1 constants
  - default DATA_WIDTH
- Sub-module parity_calc: combinational; inputs latched data and PAR_TYP, output parity bit. Reused by any future loopback checker.
- Serializer, counters and FSM remain in uart_tx.

Test Plan:
- Basic frame. Stimulus: Prescale=8, PAR_EN=0, P_DATA=0xA5, one-cycle Data_Valid. Required: TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 8 cycles; busy high exactly 80 cycles.
- Parity. Stimulus: PAR_EN=1, Prescale=16, P_DATA=0xA5 sent with even then odd parity, then P_DATA=0x07 with even parity. Required parity bits, in order: 0, 1, 1. Frame = 176 cycles.
- Busy ignore. Stimulus: Data_Valid pulsed with 0x3C in the middle of an 0xA5 frame. Required: only 0xA5 transmitted, then TX_OUT stays 1 and busy=0.
- Back-to-back. Stimulus: Data_Valid held high, P_DATA 0x55 then 0xAA. Required: two complete frames separated by exactly 1 idle-high cycle.
- Reset mid-frame. Stimulus: RST asserted during DATA bit 3. Required: TX_OUT=1 and busy=0 asynchronously; the next frame after release is correct from its start bit.
- UART_TX_TWO_STOP_EN defined. Stimulus: Prescale=8, PAR_EN=1. Required: stop high for 16 cycles; busy high 96 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path and any future
// loopback/receive-side checker.
//   uart_state_t       : transmitter FSM state encoding
//   PAR_EVEN, PAR_ODD  : values of the PAR_TYP control bit
//   UART_DATA_WIDTH    : default payload width
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// parity_calc: combinational parity generator.
// The polarity matches the receive-side checker.
//   data       : latched payload
//   par_typ    : PAR_ODD or PAR_EVEN
//   parity_bit : bit to place on the line after the payload
module parity_calc
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  par_typ,
    output logic                  parity_bit
);

    // Even: the XOR of the payload. Odd: its complement.
    assign parity_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer.
// Frame = start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Each bit is Prescale clock cycles wide; a Prescale of 0 is treated as 1.
// Ports:
//   CLK, RST    : clock (rising edge), asynchronous active-low reset
//   P_DATA      : payload, latched on acceptance
//   Data_Valid  : send request, accepted only in IDLE
//   PAR_EN      : insert parity bit (latched on acceptance)
//   PAR_TYP     : 1 = odd, 0 = even (latched on acceptance)
//   Prescale    : cycles per bit (latched on acceptance)
//   TX_OUT      : registered serial line, idle high
//   busy        : registered, high while a frame is in progress
// Build option: UART_TX_TWO_STOP_EN gives two stop bits (STOP lasts
// 2*Prescale cycles); busy still falls at the end of the final stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for Data_Valid
// START  | driving the start bit (0)
// DATA   | driving data[bit_idx]
// PARITY | driving the parity bit
// STOP   | driving the stop bit(s) (1)
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_TWO_STOP_EN
    localparam logic TWO_STOP = 1'b1;
`else
    localparam logic TWO_STOP = 1'b0;
`endif

    uart_state_t           state;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] cyc_cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [IDX_W-1:0]      idx_nxt;
    logic                  stop_second;
    logic                  last_cyc;
    logic                  parity_bit;

    parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
        .data       (data_q),
        .par_typ    (par_typ_q),
        .parity_bit (parity_bit)
    );

    // prescale_q is never 0 while a frame is active, so the subtraction
    // cannot wrap during a frame.
    assign last_cyc = (cyc_cnt == (prescale_q - PRESCALE_W'(1)));
    assign idx_nxt  = bit_idx + IDX_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            data_q      <= '0;
            par_en_q    <= 1'b0;
            par_typ_q   <= 1'b0;
            prescale_q  <= '0;
            cyc_cnt     <= '0;
            bit_idx     <= '0;
            stop_second <= 1'b0;
            TX_OUT      <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Data_Valid) begin
                        data_q      <= P_DATA;
                        par_en_q    <= PAR_EN;
                        par_typ_q   <= PAR_TYP;
                        prescale_q  <= (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
                        cyc_cnt     <= '0;
                        bit_idx     <= '0;
                        stop_second <= 1'b0;
                        TX_OUT      <= 1'b0;
                        busy        <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (last_cyc) begin
                        cyc_cnt <= '0;
                        TX_OUT  <= data_q[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_W'(1);
                    end
                end
                DATA: begin
                    if (last_cyc) begin
                        cyc_cnt <= '0;
                        if (bit_idx == LAST_IDX) begin
                            if (par_en_q) begin
                                TX_OUT <= parity_bit;
                                state  <= PARITY;
                            end else begin
                                TX_OUT <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx <= idx_nxt;
                            TX_OUT  <= data_q[idx_nxt];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_W'(1);
                    end
                end
                PARITY: begin
                    if (last_cyc) begin
                        cyc_cnt <= '0;
                        TX_OUT  <= 1'b1;
                        state   <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_W'(1);
                    end
                end
                STOP: begin
                    if (last_cyc) begin
                        cyc_cnt <= '0;
                        if (TWO_STOP && !stop_second) begin
                            stop_second <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + PRESCALE_W'(1);
                    end
                end
                default: begin
                    TX_OUT <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
